// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings, default bit timing, and
// the command byte values exchanged between the receiver, parser and TX side.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // 100 MHz system clock, 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  localparam logic [7:0] CMD_SELECT  = 8'h53;
  localparam logic [7:0] CMD_QUARTER = 8'h51;
  localparam logic [7:0] CMD_DIME    = 8'h44;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RST_VAL sets the
// value both flops take in reset, so an idle-high line does not look active.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, producing one-cycle byte / framing-error strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and flag parity errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err,
  output logic       rx_parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_sync;
  uart_state_e      state, state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic [7:0]       rx_byte_nxt;
  logic             dv_nxt;
  logic             ferr_nxt;
  logic             parity_ok;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx_serial),
    .q    (rx_sync)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_nxt;
  logic perr_nxt;

  assign parity_ok = ((^shift_reg) == par_bit);
`else
  assign parity_ok     = 1'b1;
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      rx_byte      <= '0;
      rx_dv        <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      clk_cnt      <= clk_cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      shift_reg    <= shift_nxt;
      rx_byte      <= rx_byte_nxt;
      rx_dv        <= dv_nxt;
      rx_frame_err <= ferr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit       <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      par_bit       <= par_bit_nxt;
      rx_parity_err <= perr_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    rx_byte_nxt = rx_byte;
    dv_nxt      = 1'b0;
    ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nxt = par_bit;
    perr_nxt    = 1'b0;
`endif

    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (!rx_sync) state_nxt = START;
      end

      // Re-check mid start bit so short line glitches are dropped silently
      START: begin
        if (clk_cnt == HALF) begin
          clk_cnt_nxt = '0;
          state_nxt   = rx_sync ? IDLE : DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

      DATA: begin
        if (clk_cnt == LAST) begin
          clk_cnt_nxt        = '0;
          shift_nxt[bit_idx] = rx_sync;
          if (bit_idx == 3'd7) begin
            bit_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
            state_nxt   = PARITY;
`else
            state_nxt   = STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == LAST) begin
          clk_cnt_nxt = '0;
          par_bit_nxt = rx_sync;
          state_nxt   = STOP;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
`endif

      // Leave at mid stop bit so a back-to-back start edge is not missed
      STOP: begin
        if (clk_cnt == LAST) begin
          clk_cnt_nxt = '0;
          state_nxt   = IDLE;
          if (!rx_sync) begin
            ferr_nxt = 1'b1;
          end else if (parity_ok) begin
            dv_nxt      = 1'b1;
            rx_byte_nxt = shift_reg;
          end else begin
`ifdef UART_RX_PARITY_EN
            perr_nxt = 1'b1;
`endif
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt   = IDLE;
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=16; parity cases run when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 4 + HALF + 10 * CPB;
`else
  localparam int LAT = 4 + HALF + 9 * CPB;
`endif

  logic       clk;
  logic       reset;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_frame_err;
  logic       rx_parity_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         kind;  // 0 = byte, 1 = frame error, 2 = parity error
    logic [7:0] b;
    int         t0;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_serial    (rx_serial),
    .rx_dv        (rx_dv),
    .rx_byte      (rx_byte),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_serial = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
    exp_t e;
    e.t0 = cyc;
    if (!stop_v) begin
      e.kind = 1;
      e.b    = last_good;
    end else if (par_flip) begin
      e.kind = 2;
      e.b    = last_good;
    end else begin
      e.kind    = 0;
      e.b       = b;
      last_good = b;
    end
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_v);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  // Output monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   kind_obs;
    int   lat;
    if (!reset && (rx_dv || rx_frame_err || rx_parity_err)) begin
      chk("strobe_excl", 32'(int'(rx_dv) + int'(rx_frame_err) + int'(rx_parity_err)), 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {29'd0, rx_dv, rx_frame_err, rx_parity_err}, 32'd0);
      end else begin
        e        = sb.pop_front();
        kind_obs = rx_dv ? 0 : (rx_frame_err ? 1 : 2);
        lat      = cyc - e.t0;
        chk("strobe_kind", 32'(kind_obs), 32'(e.kind));
        chk("rx_byte", {24'd0, rx_byte}, {24'd0, e.b});
        chk("latency", 32'(lat), (lat >= LAT - 1 && lat <= LAT + 1) ? 32'(lat) : 32'(LAT));
      end
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * LAT && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    reset     = 1'b1;
    rx_serial = 1'b1;
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dv", {31'd0, rx_dv}, 32'd0);
    chk("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
    chk("rst_perr", {31'd0, rx_parity_err}, 32'd0);
    chk("rst_byte", {24'd0, rx_byte}, 32'd0);
    reset = 1'b0;
    idle_bits(2);

    send_frame(CMD_SELECT, 1'b1, 1'b0);
    idle_bits(2);

    send_frame(CMD_QUARTER, 1'b1, 1'b0);
    send_frame(CMD_DIME, 1'b1, 1'b0);
    idle_bits(2);
    drain("drain_b2b");

    // 5-clk glitch on an idle line must produce nothing
    rx_serial = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_serial = 1'b1;
    idle_bits(3);
    chk("glitch_sb", 32'(sb.size()), 32'd0);

    send_frame(CMD_SELECT, 1'b1, 1'b0);
    idle_bits(2);

    send_frame(8'hA5, 1'b0, 1'b0);
    idle_bits(3);
    drain("drain_ferr");

    // Abort a 0x44 frame with reset halfway through data bit 4
    rb = CMD_DIME;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rb[i]);
    rx_serial = rb[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_dv", {31'd0, rx_dv}, 32'd0);
    chk("midrst_ferr", {31'd0, rx_frame_err}, 32'd0);
    chk("midrst_perr", {31'd0, rx_parity_err}, 32'd0);
    chk("midrst_byte", {24'd0, rx_byte}, 32'd0);
    last_good = 8'h00;
    rx_serial = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_bits(2);

    send_frame(CMD_DIME, 1'b1, 1'b0);
    idle_bits(2);

`ifdef UART_RX_PARITY_EN
    send_frame(CMD_SELECT, 1'b1, 1'b0);
    idle_bits(2);
    send_frame(CMD_SELECT, 1'b1, 1'b1);
    idle_bits(2);
`endif

    drain("drain_end");
    chk("final_byte", {24'd0, rx_byte}, {24'd0, last_good});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
